refresh_scheduler: RTL and testbench
====================================

# refresh_scheduler

- Generates DRAM refresh demand for the RAM controller: `RefReq` (refresh wanted) and `RefUrgent` (refresh must preempt RAM accesses).
- Consumes `RefAck` from the controller to retire completed refreshes.
- Tracks owed refreshes in a saturating debt counter fed by a fixed-period timer.
- Sits beside the RAM controller in the CPLD top level, one instance per DRAM bank set.

## Interface
- PERIOD, 375, clocks between refresh slots (15 µs at 25 MHz); legal range 4..4095.
- URGENT_DEBT, 2, debt at or above which RefUrgent asserts; 1 ≤ URGENT_DEBT ≤ MAX_DEBT.
- MAX_DEBT, 7, debt saturation value; ≤ 15.
- CLK  input  1  system clock; all state on posedge.
- nRST  input  1  reset; asynchronous assert, active-low.
- En  input  1  timer enable; low freezes the timer, but acks still retire debt.
- RefAck  input  1  high while the controller drives refresh RAS; one high run = one refresh.
- RefReq  output  1  registered; debt ≠ 0.
- RefUrgent  output  1  registered; debt ≥ URGENT_DEBT.
- Debt  output  4  registered current debt.
- Tick  output  1  registered one-cycle pulse when a refresh slot elapses.
- Overrun  output  1  sticky error: a slot elapsed while debt was already MAX_DEBT.

## Operation
- Timer:
  - Down-counter, 12 bits, reloads to PERIOD-1.
  - When En=1, it decrements each clock.
  - At 0 it reloads and produces slot event T.
  - When En=0, it holds its value; no T.
- Ack detect:
  - RefAckr is RefAck registered.
  - A = RefAck & ~RefAckr, i.e. the first cycle of each high run.
  - A multi-cycle high run counts once.
- Debt update, evaluated once per clock:
  - T & ~A: if debt < MAX_DEBT, debt+1; else debt holds and Overrun←1.
  - A & ~T: if debt > 0, debt-1; else debt holds at 0 (spurious ack ignored, no error).
  - T & A: debt unchanged, and Overrun is not set even at MAX_DEBT.
  - Neither: debt holds.
- Outputs:
  - Debt, RefReq and RefUrgent are registered from the next-state debt, so they always agree with the Debt output.
  - Tick is the registered T.
  - Overrun clears only on reset.
- Demand states, derived from debt:
  - IDLE (debt 0): RefReq=0, RefUrgent=0.
  - PEND (1 ≤ debt < URGENT_DEBT): RefReq=1, RefUrgent=0.
  - URG (debt ≥ URGENT_DEBT): RefReq=1, RefUrgent=1.
  - SAT (debt = MAX_DEBT): as URG, and overrun-capable.
- Transitions move at most one state per clock.

## Timing
- Reset (nRST low, asynchronous):
  - Timer = PERIOD-1, debt = 0, RefAckr = 0.
  - RefReq = RefUrgent = Tick = Overrun = 0; Debt = 0.
- After nRST deasserts with En=1:
  - The first T occurs on the PERIOD-th rising edge.
  - Tick and RefReq go high after that same edge.
  - Slots then repeat every PERIOD clocks exactly. Slot phase is independent of acks.
- Ack latency:
  - RefAck first sampled high at edge k ⇒ Debt decremented and RefReq/RefUrgent updated after edge k.
  - The controller therefore sees a lowered request within its refresh sequence, before it returns to idle.
- RefAck already high when nRST deasserts:
  - Counts as one ack on the first edge.
  - Debt is 0 then, so the ack is ignored.
- En toggling:
  - The timer resumes from its held value; no slot is lost or duplicated.
- Reset mid-operation:
  - All state returns to reset values immediately.
  - Owed refreshes are discarded.

## Structure
- Shared package `warp_pkg`:
  - Constants REF_PERIOD_25M=375, REF_URGENT_DEBT=2, REF_MAX_DEBT=7.
  - Debt width constant DEBT_W=4.
- One sub-module, `refresh_timer`:
  - Reloadable down-counter with En.
  - Outputs the one-cycle slot event T.
  - Parameter PERIOD.
- Debt logic, ack detect and output registers live in refresh_scheduler.

## Test plan
- Reset/first slot: PERIOD=8, En=1, no acks → Tick pulses at cycles 8, 16, 24; Debt 1, 2, 3; RefReq rises at 8, RefUrgent rises at 16.
- Ack retire: debt 2, RefAck high for 2 cycles → Debt=1 one edge after RefAck rises (not 0), RefUrgent drops, RefReq stays 1.
- Simultaneous events: RefAck rising on the same edge as T with debt 3 → Debt stays 3; no Overrun.
- Saturation: PERIOD=8, no acks for 64 cycles → Debt sticks at 7; Overrun sets on the 8th slot and stays 1 after acks drain debt to 0.
- Spurious ack and En hold:
  - Debt 0, RefAck pulse → Debt stays 0, Overrun 0.
  - En low for 5 cycles mid-period → next Tick delayed exactly 5 cycles.
- Async reset mid-operation: nRST pulled low between edges with debt 5 → all outputs 0 immediately; the first Tick comes PERIOD edges after release.

Source files
------------

// File: rtl/warp_pkg.sv
// warp_pkg
//   Constants and helpers shared across the CPLD top level.
//   Refresh constants describe a 15 us refresh slot at 25 MHz and the debt
//   thresholds used by refresh_scheduler.
//   demandOf() classifies a refresh debt value into a demand state.
package warp_pkg;

   localparam int REF_PERIOD_25M  = 375;
   localparam int REF_URGENT_DEBT = 2;
   localparam int REF_MAX_DEBT    = 7;
   localparam int DEBT_W          = 4;

   typedef enum logic [1:0] {
      DEMAND_IDLE,   // nothing owed
      DEMAND_PEND,   // owed, but RAM accesses may still go first
      DEMAND_URG,    // owed enough that refresh must preempt RAM accesses
      DEMAND_SAT     // debt saturated; a further slot is an overrun
   } demandState_t;

   function automatic demandState_t demandOf(input logic [DEBT_W-1:0] debt,
                                             input int urgentDebt,
                                             input int maxDebt);
      demandState_t st;
      if (int'(debt) == 0)                st = DEMAND_IDLE;
      else if (int'(debt) >= maxDebt)     st = DEMAND_SAT;
      else if (int'(debt) >= urgentDebt)  st = DEMAND_URG;
      else                                st = DEMAND_PEND;
      return st;
   endfunction

endpackage

// File: rtl/refresh_timer.sv
// refresh_timer
//   Free-running slot timer: a 12-bit down-counter that reloads to PERIOD-1
//   and flags a slot event T in the cycle it sits at zero while enabled.
//   With En low the count is frozen, so a slot is only delayed, never lost.
// Ports:
//   CLK  - system clock
//   nRST - asynchronous active-low reset (count returns to PERIOD-1)
//   En   - count enable
//   T    - slot event, combinational, high for the one enabled cycle at zero
module refresh_timer #(
   parameter int PERIOD = 375
) (
   input  logic CLK,
   input  logic nRST,
   input  logic En,
   output logic T
);

   localparam logic [11:0] RELOAD = 12'(PERIOD - 1);

   logic [11:0] countReg;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         countReg <= RELOAD;
      end else if (En) begin
         if (countReg == 12'd0)
            countReg <= RELOAD;
         else
            countReg <= countReg - 12'd1;
      end
   end

   // Reload-from-zero makes the slot spacing exactly PERIOD enabled clocks.
   assign T = En && (countReg == 12'd0);

endmodule

// File: rtl/refresh_scheduler.sv
// refresh_scheduler
//   Turns a fixed-period refresh timer into refresh demand for the RAM
//   controller. Each elapsed slot adds one refresh to a saturating debt;
//   each refresh performed by the controller (one RefAck high run) retires
//   one. The demand outputs are derived from that debt.
// Ports:
//   CLK       - system clock
//   nRST      - asynchronous active-low reset
//   En        - timer enable (acks still retire debt while low)
//   RefAck    - high while the controller drives refresh RAS
//   RefReq    - registered, debt != 0
//   RefUrgent - registered, debt >= URGENT_DEBT
//   Debt      - registered current debt
//   Tick      - registered one-cycle pulse per elapsed slot
//   Overrun   - sticky: a slot elapsed with debt already at MAX_DEBT
module refresh_scheduler
   import warp_pkg::*;
#(
   parameter int PERIOD      = REF_PERIOD_25M,
   parameter int URGENT_DEBT = REF_URGENT_DEBT,
   parameter int MAX_DEBT    = REF_MAX_DEBT
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              En,
   input  logic              RefAck,
   output logic              RefReq,
   output logic              RefUrgent,
   output logic [DEBT_W-1:0] Debt,
   output logic              Tick,
   output logic              Overrun
);

   localparam logic [DEBT_W-1:0] MAX_D = DEBT_W'(MAX_DEBT);

   logic              slotT;
   logic              refAckr;
   logic              ackA;
   logic [DEBT_W-1:0] debtNext;
   logic              overrunNext;
   demandState_t      demandNext;

   refresh_timer #(
      .PERIOD (PERIOD)
   ) uTimer (
      .CLK  (CLK),
      .nRST (nRST),
      .En   (En),
      .T    (slotT)
   );

   // Rising edge of RefAck: a multi-cycle RAS run retires only one refresh.
   // refAckr resets to 0, so an ack already high at reset release counts once.
   assign ackA = RefAck && !refAckr;

   always_comb begin
      debtNext    = Debt;
      overrunNext = Overrun;
      if (slotT && !ackA) begin
         if (Debt < MAX_D)
            debtNext = Debt + 4'd1;
         else
            overrunNext = 1'b1;
      end else if (ackA && !slotT) begin
         // An ack with nothing owed is ignored rather than flagged.
         if (Debt != '0)
            debtNext = Debt - 4'd1;
      end
      // Slot and ack together cancel; no overrun even when saturated.
      demandNext = demandOf(debtNext, URGENT_DEBT, MAX_DEBT);
   end

   // Demand outputs come from the next-state debt so they never lag Debt.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         refAckr   <= 1'b0;
         Debt      <= '0;
         Overrun   <= 1'b0;
         Tick      <= 1'b0;
         RefReq    <= 1'b0;
         RefUrgent <= 1'b0;
      end else begin
         refAckr   <= RefAck;
         Debt      <= debtNext;
         Overrun   <= overrunNext;
         Tick      <= slotT;
         RefReq    <= (demandNext != DEMAND_IDLE);
         RefUrgent <= (demandNext == DEMAND_URG) || (demandNext == DEMAND_SAT);
      end
   end

endmodule

// File: tb/tb_refresh_scheduler.sv
// tb_refresh_scheduler
//   Self-checking bench for refresh_scheduler with PERIOD=8, URGENT_DEBT=2,
//   MAX_DEBT=7. Expected outputs are queued when each cycle's stimulus is
//   driven and popped for comparison just after the following clock edge.
module tb_refresh_scheduler;

   logic       CLK;
   logic       nRST;
   logic       En;
   logic       RefAck;
   logic       RefReq;
   logic       RefUrgent;
   logic [3:0] Debt;
   logic       Tick;
   logic       Overrun;

   refresh_scheduler #(
      .PERIOD      (8),
      .URGENT_DEBT (2),
      .MAX_DEBT    (7)
   ) dut (
      .CLK       (CLK),
      .nRST      (nRST),
      .En        (En),
      .RefAck    (RefAck),
      .RefReq    (RefReq),
      .RefUrgent (RefUrgent),
      .Debt      (Debt),
      .Tick      (Tick),
      .Overrun   (Overrun)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      int n;
      bit en;
      bit ack;
      bit tick;
      int debt;
      bit req;
      bit urg;
      bit ovr;
   } seg_t;

   typedef struct {
      bit tick;
      int debt;
      bit req;
      bit urg;
      bit ovr;
   } exp_t;

   seg_t tbl[$];
   exp_t sbQ[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   task automatic addSeg(input int n, input bit en, input bit ack, input bit tick,
                         input int debt, input bit req, input bit urg, input bit ovr);
      seg_t s;
      s.n = n; s.en = en; s.ack = ack; s.tick = tick;
      s.debt = debt; s.req = req; s.urg = urg; s.ovr = ovr;
      tbl.push_back(s);
   endtask

   task automatic checkNow(input string tag, input exp_t e);
      logic [7:0] act, req;
      act = {Tick, Debt, RefReq, RefUrgent, Overrun};
      req = {e.tick, 4'(e.debt), e.req, e.urg, e.ovr};
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s cyc=%0d got tick=%b debt=%0d req=%b urg=%b ovr=%b want tick=%b debt=%0d req=%b urg=%b ovr=%b",
                  tag, cyc, Tick, Debt, RefReq, RefUrgent, Overrun,
                  e.tick, e.debt, e.req, e.urg, e.ovr);
      end
   endtask

   // Drive one cycle of stimulus, queue its expectation, check after the edge.
   task automatic step(input string tag, input bit en, input bit ack, input exp_t e);
      exp_t got;
      En     = en;
      RefAck = ack;
      sbQ.push_back(e);
      @(posedge CLK);
      #1;
      cyc++;
      got = sbQ.pop_front();
      checkNow(tag, got);
      $display("cyc=%0d %s en=%b ack=%b tick=%b debt=%0d req=%b urg=%b ovr=%b",
               cyc, tag, en, ack, Tick, Debt, RefReq, RefUrgent, Overrun);
   endtask

   function automatic exp_t mkExp(input bit tick, input int debt, input bit ovr);
      exp_t e;
      e.tick = tick;
      e.debt = debt;
      e.req  = (debt != 0);
      e.urg  = (debt >= 2);
      e.ovr  = ovr;
      return e;
   endfunction

   // Assert reset between edges, check outputs cleared immediately, then
   // release on a falling edge so the next rising edge is cycle 1.
   task automatic doReset(input string tag, input bit ackAtRelease);
      exp_t z;
      z = mkExp(1'b0, 0, 1'b0);
      #2;
      nRST = 1'b0;
      #1;
      checkNow(tag, z);
      $display("reset %s tick=%b debt=%0d req=%b urg=%b ovr=%b",
               tag, Tick, Debt, RefReq, RefUrgent, Overrun);
      @(posedge CLK);
      #1;
      checkNow({tag, "_held"}, z);
      En     = 1'b1;
      RefAck = ackAtRelease;
      @(negedge CLK);
      nRST = 1'b1;
      cyc  = 0;
   endtask

   // No acks, En high: debt follows the slot count, saturating at 7.
   task automatic freeRun(input string tag, input int n);
      for (int c = 1; c <= n; c++) begin
         int d;
         d = c / 8;
         if (d > 7) d = 7;
         step(tag, 1'b1, 1'b0, mkExp((c % 8) == 0, d, c >= 64));
      end
   endtask

   initial begin
      nRST   = 1'b1;
      En     = 1'b0;
      RefAck = 1'b0;
      #1;

      // Table-driven main sequence (cycle numbers are edges after release).
      addSeg(7, 1, 0, 0, 0, 0, 0, 0);  // 1-7
      addSeg(1, 1, 0, 1, 1, 1, 0, 0);  // 8  first slot
      addSeg(7, 1, 0, 0, 1, 1, 0, 0);
      addSeg(1, 1, 0, 1, 2, 1, 1, 0);  // 16 urgent
      addSeg(7, 1, 0, 0, 2, 1, 1, 0);
      addSeg(1, 1, 0, 1, 3, 1, 1, 0);  // 24
      addSeg(7, 1, 0, 0, 3, 1, 1, 0);
      addSeg(1, 1, 1, 1, 3, 1, 1, 0);  // 32 ack and slot together
      addSeg(1, 1, 1, 0, 3, 1, 1, 0);  // same run, no second ack
      addSeg(1, 1, 0, 0, 3, 1, 1, 0);
      addSeg(1, 1, 1, 0, 2, 1, 1, 0);  // 35 ack 3->2
      addSeg(1, 1, 1, 0, 2, 1, 1, 0);
      addSeg(1, 1, 0, 0, 2, 1, 1, 0);
      addSeg(1, 1, 1, 0, 1, 1, 0, 0);  // 38 ack 2->1, urgent drops
      addSeg(1, 1, 1, 0, 1, 1, 0, 0);
      addSeg(1, 1, 0, 1, 2, 1, 1, 0);  // 40 slot
      addSeg(1, 1, 1, 0, 1, 1, 0, 0);  // 41
      addSeg(1, 1, 0, 0, 1, 1, 0, 0);
      addSeg(1, 1, 1, 0, 0, 0, 0, 0);  // 43 drained
      addSeg(1, 1, 0, 0, 0, 0, 0, 0);
      addSeg(1, 1, 1, 0, 0, 0, 0, 0);  // 45 spurious ack
      addSeg(2, 1, 0, 0, 0, 0, 0, 0);
      addSeg(1, 1, 0, 1, 1, 1, 0, 0);  // 48 slot
      addSeg(2, 1, 0, 0, 1, 1, 0, 0);
      addSeg(1, 0, 0, 0, 1, 1, 0, 0);  // 51 En low begins
      addSeg(1, 0, 1, 0, 0, 0, 0, 0);  // 52 ack retires with En low
      addSeg(3, 0, 0, 0, 0, 0, 0, 0);  // 53-55
      addSeg(5, 1, 0, 0, 0, 0, 0, 0);  // 56-60
      addSeg(1, 1, 0, 1, 1, 1, 0, 0);  // 61 slot delayed by 5
      addSeg(7, 1, 0, 0, 1, 1, 0, 0);
      addSeg(1, 1, 0, 1, 2, 1, 1, 0);  // 69

      doReset("reset_init", 1'b0);
      foreach (tbl[i]) begin
         for (int k = 0; k < tbl[i].n; k++) begin
            exp_t e;
            e.tick = tbl[i].tick; e.debt = tbl[i].debt;
            e.req  = tbl[i].req;  e.urg  = tbl[i].urg; e.ovr = tbl[i].ovr;
            step($sformatf("tbl%0d", i), tbl[i].en, tbl[i].ack, e);
         end
      end

      // Saturation: overrun sets on the 8th slot (edge 64) and is sticky.
      doReset("reset_sat", 1'b0);
      freeRun("sat", 70);
      for (int p = 1; p <= 7; p++) begin
         step("drain_ack", 1'b0, 1'b1, mkExp(1'b0, 7 - p, 1'b1));
         step("drain_gap", 1'b0, 1'b0, mkExp(1'b0, 7 - p, 1'b1));
      end

      // Async reset with debt 5, released while RefAck is already high.
      doReset("reset_pre", 1'b0);
      freeRun("pre", 43);
      doReset("reset_mid", 1'b1);
      for (int c = 1; c <= 3; c++)
         step("post_ackhi", 1'b1, 1'b1, mkExp(1'b0, 0, 1'b0));
      for (int c = 4; c <= 7; c++)
         step("post", 1'b1, 1'b0, mkExp(1'b0, 0, 1'b0));
      step("post_slot", 1'b1, 1'b0, mkExp(1'b1, 1, 1'b0));
      step("post_after", 1'b1, 1'b0, mkExp(1'b0, 1, 1'b0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
